// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and state type for the fetch window buffer
package fetch_pkg;
    localparam int WINDOW_BYTES = 15;
    localparam int FETCH_BYTES  = 8;

    typedef enum logic {FW_IDLE, FW_RUN} fetch_state_t;
endpackage

// File: rtl/fetch_window_buffer_byte_queue.sv
// rtl/fetch_window_buffer_byte_queue.sv - shift-down byte store with offset append and head window
module byte_queue
    import fetch_pkg::*;
#(
    parameter int  BUF_BYTES = 32,
    localparam int CW        = $clog2(BUF_BYTES + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [CW-1:0]             pop,
    input  logic                      push,
    input  logic [63:0]               push_data,
    input  logic [2:0]                push_skip,
    output logic [8*WINDOW_BYTES-1:0] head,
    output logic [CW-1:0]             count
);

    logic [8*BUF_BYTES-1:0] data;
    logic [8*BUF_BYTES-1:0] shifted;
    logic [8*BUF_BYTES-1:0] incoming;
    logic [CW-1:0]          base;
    logic [CW-1:0]          push_len;

    // Bytes at or above count are always zero, so the append can simply be OR-ed in.
    always_comb begin
        shifted  = data >> {pop, 3'b000};
        base     = count - pop;
        push_len = CW'(FETCH_BYTES) - CW'(push_skip);
        incoming = '0;
        if (push) begin
            incoming = {{(8*BUF_BYTES-64){1'b0}}, push_data >> {push_skip, 3'b000}} << {base, 3'b000};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            data  <= '0;
            count <= '0;
        end else begin
            data  <= shifted | incoming;
            count <= push ? base + push_len : base;
        end
    end

    assign head = data[8*WINDOW_BYTES-1:0];

endmodule

// File: rtl/fetch_window_buffer.sv
// rtl/fetch_window_buffer.sv - aligned fetch issue, in-order response queueing and 15-byte decode window
module fetch_window_buffer
    import fetch_pkg::*;
#(
    parameter int BUF_BYTES       = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          redirect_valid,
    input  logic [63:0]   redirect_pc,
    output logic          fetch_req_valid,
    output logic [63:0]   fetch_req_addr,
    input  logic          fetch_req_ready,
    input  logic          fetch_resp_valid,
    input  logic [63:0]   fetch_resp_data,
    output logic [0:119]  window,
    output logic [4:0]    window_bytes,
    output logic          window_valid,
    output logic [63:0]   window_pc,
    input  logic          consume_valid,
    input  logic [3:0]    byte_incr
);

    localparam int CW = $clog2(BUF_BYTES + 1);

    fetch_state_t               state, state_next;
    logic [63:0]                fetch_addr;
    logic [2:0]                 outstanding;
    logic [2:0]                 drop_cnt;
    logic [2:0]                 skip;
    logic [CW-1:0]              count;
    logic [8*WINDOW_BYTES-1:0]  head;
    logic [3:0]                 in_flight;
    logic                       space_ok;
    logic                       req_fire;
    logic                       resp_any;
    logic                       resp_take;
    logic                       resp_drop;
    logic [4:0]                 eff;

    assign in_flight = {1'b0, outstanding} + {1'b0, drop_cnt};
    // Reserve a full 8 bytes per live request; stale ones land nowhere.
    assign space_ok  = (16'(count) + 16'({outstanding, 3'b000}) + 16'(FETCH_BYTES)) <= 16'(BUF_BYTES);
    assign req_fire  = fetch_req_valid && fetch_req_ready;
    assign resp_any  = fetch_resp_valid && (in_flight != 4'd0);
    assign resp_take = fetch_resp_valid && !redirect_valid && (drop_cnt == 3'd0) && (outstanding != 3'd0);
    assign resp_drop = fetch_resp_valid && !redirect_valid && (drop_cnt != 3'd0);

    always_ff @(posedge clk) begin
        if (!reset) state <= FW_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (redirect_valid) state_next = FW_RUN;
    end

    always_comb begin
        fetch_req_valid = (state == FW_RUN) && space_ok && (in_flight < 4'(MAX_OUTSTANDING));
    end

    assign fetch_req_addr = fetch_addr;
    assign window_bytes   = (count > CW'(WINDOW_BYTES)) ? 5'd15 : 5'(count);
    assign window_valid   = (window_bytes == 5'd15);

    always_comb begin
        eff = 5'd0;
        if (consume_valid) eff = ({1'b0, byte_incr} > window_bytes) ? window_bytes : {1'b0, byte_incr};
    end

    always_comb begin
        window = '0;
        for (int k = 0; k < WINDOW_BYTES; k++) window[8*k +: 8] = head[8*k +: 8];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_addr  <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            skip        <= '0;
            window_pc   <= '0;
        end else if (redirect_valid) begin
            fetch_addr  <= {redirect_pc[63:3], 3'b000};
            skip        <= redirect_pc[2:0];
            window_pc   <= redirect_pc;
            outstanding <= '0;
            drop_cnt    <= 3'(in_flight + 4'(req_fire) - 4'(resp_any));
        end else begin
            if (req_fire)  fetch_addr <= fetch_addr + 64'd8;
            if (resp_drop) drop_cnt   <= drop_cnt - 3'd1;
            if (resp_take) skip       <= 3'd0;
            outstanding <= outstanding + 3'(req_fire) - 3'(resp_take);
            window_pc   <= window_pc + 64'(eff);
        end
    end

    byte_queue #(.BUF_BYTES(BUF_BYTES)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .pop       (redirect_valid ? CW'(0) : CW'(eff)),
        .push      (resp_take),
        .push_data (fetch_resp_data),
        .push_skip (skip),
        .head      (head),
        .count     (count)
    );

endmodule

// File: tb/tb_fetch_window_buffer.sv
// tb/tb_fetch_window_buffer.sv - scoreboard bench with address-derived memory and byte-level reference model
module tb_fetch_window_buffer;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         redirect_valid = 1'b0;
    logic [63:0]  redirect_pc = '0;
    logic         fetch_req_valid;
    logic [63:0]  fetch_req_addr;
    logic         fetch_req_ready = 1'b0;
    logic         fetch_resp_valid = 1'b0;
    logic [63:0]  fetch_resp_data = '0;
    logic [0:119] window;
    logic [4:0]   window_bytes;
    logic         window_valid;
    logic [63:0]  window_pc;
    logic         consume_valid = 1'b0;
    logic [3:0]   byte_incr = '0;

    always #5 clk = ~clk;

    fetch_window_buffer #(.BUF_BYTES(32), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_req_valid(fetch_req_valid), .fetch_req_addr(fetch_req_addr), .fetch_req_ready(fetch_req_ready),
        .fetch_resp_valid(fetch_resp_valid), .fetch_resp_data(fetch_resp_data),
        .window(window), .window_bytes(window_bytes), .window_valid(window_valid), .window_pc(window_pc),
        .consume_valid(consume_valid), .byte_incr(byte_incr)
    );

    typedef struct { logic [63:0] addr; int epoch; } req_t;
    typedef struct { logic rv; logic [63:0] raddr; logic [63:0] pc; logic [4:0] nb; logic [0:119] win; } exp_t;

    req_t rq[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    bit          m_run = 0;
    bit          m_valid = 0;
    int          m_count = 0;
    int          m_skip = 0;
    int          cur_epoch = 0;
    logic [63:0] m_pc = '0;
    logic [63:0] m_next = '0;

    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        return a[7:0] ^ {a[11:8], a[11:8]};
    endfunction

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = mem_byte(a + 64'(i));
        return w;
    endfunction

    function automatic int nb_of(input int c);
        return (c > 15) ? 15 : c;
    endfunction

    function automatic bit calc_valid();
        int live = 0;
        foreach (rq[i]) if (rq[i].epoch == cur_epoch) live++;
        return m_run && (m_count + 8*live + 8 <= 32) && (rq.size() < 2);
    endfunction

    task automatic push_req(input logic [63:0] a, input int ep);
        req_t r;
        r.addr = a;
        r.epoch = ep;
        rq.push_back(r);
    endtask

    task automatic push_expect();
        exp_t e;
        int nb;
        nb = nb_of(m_count);
        e.rv = m_valid;
        e.raddr = m_next;
        e.pc = m_pc;
        e.nb = 5'(nb);
        e.win = '0;
        for (int k = 0; k < 15; k++) if (k < nb) e.win[8*k +: 8] = mem_byte(m_pc + 64'(k));
        sb.push_back(e);
    endtask

    task automatic model_step();
        req_t got;
        bit   fire, have;
        int   eff;
        fire = m_valid && fetch_req_ready;
        have = 0;
        if (fetch_resp_valid && rq.size() > 0) begin
            got = rq.pop_front();
            have = 1;
        end
        if (!reset) begin
            if (fire) push_req(m_next, cur_epoch);
            cur_epoch++;
            m_run = 0; m_count = 0; m_skip = 0; m_pc = '0; m_next = '0;
        end else if (redirect_valid) begin
            if (fire) push_req(m_next, cur_epoch);
            cur_epoch++;
            m_run = 1; m_count = 0;
            m_pc = redirect_pc;
            m_next = {redirect_pc[63:3], 3'b000};
            m_skip = int'(redirect_pc[2:0]);
        end else begin
            if (consume_valid) begin
                eff = (int'(byte_incr) < nb_of(m_count)) ? int'(byte_incr) : nb_of(m_count);
                m_count -= eff;
                m_pc += 64'(eff);
            end
            if (have && got.epoch == cur_epoch) begin
                m_count += 8 - m_skip;
                m_skip = 0;
            end
            if (fire) begin
                push_req(m_next, cur_epoch);
                m_next += 64'd8;
            end
        end
        m_valid = calc_valid();
        push_expect();
    endtask

    task automatic step(input logic rst_n, input logic rv, input logic [63:0] rpc, input logic rdy,
                        input bit allow_resp, input logic cv, input logic [3:0] incr);
        reset = rst_n;
        redirect_valid = rv;
        redirect_pc = rpc;
        fetch_req_ready = rdy;
        consume_valid = cv;
        byte_incr = incr;
        fetch_resp_valid = 1'b0;
        fetch_resp_data = '0;
        if (allow_resp && rq.size() > 0) begin
            fetch_resp_valid = 1'b1;
            fetch_resp_data = mem_word(rq[0].addr);
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run(input int n, input bit do_consume, input int amount);
        int nb;
        for (int i = 0; i < n; i++) begin
            nb = nb_of(m_count);
            if (do_consume && nb >= amount && amount > 0) step(1, 0, '0, 1, 1, 1, 4'(amount));
            else step(1, 0, '0, 1, 1, 0, 4'd0);
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("req_valid", 128'(fetch_req_valid), 128'(e.rv));
            chk("req_addr", 128'(fetch_req_addr), 128'(e.raddr));
            chk("window_pc", 128'(window_pc), 128'(e.pc));
            chk("window_bytes", 128'(window_bytes), 128'(e.nb));
            chk("window_valid", 128'(window_valid), 128'(e.nb == 5'd15));
            chk("window", 128'(window), 128'(e.win));
        end
    end

    initial begin
        int n, nb;
        // Reset, then aligned redirect and fill to a full window
        repeat (3) step(0, 0, '0, 1, 0, 0, 4'd0);
        step(1, 1, 64'h1000, 1, 1, 0, 4'd0);
        run(8, 0, 0);
        // Unaligned target: first response contributes only 3 bytes
        step(1, 1, 64'h2005, 1, 0, 0, 4'd0);
        step(1, 0, '0, 1, 0, 0, 4'd0);
        step(1, 0, '0, 1, 1, 0, 4'd0);
        run(6, 0, 0);
        // Steady stream with 3-byte consumes
        run(60, 1, 3);
        // Redirect with two requests in flight
        n = 0;
        while (rq.size() < 2 && n < 30) begin
            nb = nb_of(m_count);
            step(1, 0, '0, 1, 0, nb > 0, 4'(nb));
            n++;
        end
        if (rq.size() < 2) bound_fail("two_in_flight");
        step(1, 1, 64'h3000, 1, 0, 0, 4'd0);
        run(12, 0, 0);
        // Backpressure on the request channel
        step(1, 1, 64'h5000, 0, 0, 0, 4'd0);
        repeat (5) step(1, 0, '0, 0, 1, 0, 4'd0);
        run(8, 1, 5);
        // Consume 15 and take a response in the same cycle
        step(1, 1, 64'h4001, 1, 0, 0, 4'd0);
        n = 0;
        while (!(m_count == 15 && rq.size() > 0) && n < 40) begin
            step(1, 0, '0, 1, m_count < 15, 0, 4'd0);
            n++;
        end
        if (!(m_count == 15 && rq.size() > 0)) bound_fail("count_15");
        step(1, 0, '0, 1, 1, 1, 4'd15);
        run(6, 0, 0);
        // Address wrap past 2^64
        step(1, 1, 64'hFFFF_FFFF_FFFF_FFF3, 1, 0, 0, 4'd0);
        run(20, 1, 4);
        // Reset mid-operation; stale responses drain and must be ignored
        step(1, 1, 64'h6000, 1, 0, 0, 4'd0);
        step(1, 0, '0, 1, 0, 0, 4'd0);
        step(1, 0, '0, 1, 0, 0, 4'd0);
        step(0, 0, '0, 1, 0, 0, 4'd0);
        step(0, 0, '0, 1, 1, 0, 4'd0);
        n = 0;
        while (rq.size() > 0 && n < 20) begin
            step(1, 0, '0, 1, 1, 0, 4'd0);
            n++;
        end
        if (rq.size() > 0) bound_fail("reset_drain");
        step(1, 1, 64'h7002, 1, 0, 0, 4'd0);
        run(10, 1, 2);
        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [63:0] pc;
            logic [3:0]  inc;
            logic        cv;
            nb = nb_of(m_count);
            cv = (nb > 0) && ($urandom % 2 == 0);
            inc = cv ? 4'($urandom_range(nb, 1)) : 4'd0;
            pc = ($urandom % 4 == 0) ? {32'hFFFF_FFFF, 32'hFFFF_FF00 | 32'($urandom % 256)} : {$urandom, $urandom};
            if ($urandom % 40 == 0) step(1, 1, pc, $urandom % 4 != 0, $urandom % 3 != 0, 0, 4'd0);
            else step(1, 0, '0, $urandom % 4 != 0, $urandom % 3 != 0, cv, inc);
        end
        repeat (3) step(1, 0, '0, 0, 0, 0, 4'd0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
